// File: rtl/gcd_pkg.sv
// Shared definitions for the binary GCD engine:
// default operand width and the FSM state encoding.
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t COMMON = 2'd1;
    localparam state_t REDUCE = 2'd2;
    localparam state_t DONE   = 2'd3;

endpackage

// File: rtl/gcd_step.sv
// One Stein reduction step (combinational).
// Ports: ra, rb in; ra_next, rb_next, done out.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    output logic [WIDTH-1:0] ra_next,
    output logic [WIDTH-1:0] rb_next,
    output logic             done
);

    logic both_odd;
    logic eq;
    logic gt;

    assign both_odd = ra[0] & rb[0];
    assign eq       = (ra == rb);
    assign gt       = (ra > rb);

    // Rule terms are made mutually exclusive so the
    // first-match order is encoded in the conditions.
    always_comb begin
        ra_next = ra;
        rb_next = rb;
        done    = 1'b0;
        unique case (1'b1)
            !ra[0]:
                ra_next = ra >> 1;
            ra[0] & !rb[0]:
                rb_next = rb >> 1;
            both_odd & eq:
                done = 1'b1;
            both_odd & gt:
                ra_next = (ra - rb) >> 1;
            default:
                rb_next = (rb - ra) >> 1;
        endcase
    end

endmodule

// File: rtl/gcd_engine.sv
// Binary (Stein) GCD engine with valid/ready handshakes.
// Ports: clk, rst, in_valid/in_ready, a, b, out_valid/out_ready, gcd, busy.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] result;
    logic [KW-1:0]    k;

    logic [WIDTH-1:0] ra_next;
    logic [WIDTH-1:0] rb_next;
    logic             step_done;

    gcd_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .ra     (ra),
        .rb     (rb),
        .ra_next(ra_next),
        .rb_next(rb_next),
        .done   (step_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            k      <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra <= a;
                        rb <= b;
                        k  <= '0;
                        // A zero operand short-circuits the reduction.
                        if (a == '0 || b == '0) begin
                            result <= a | b;
                            state  <= DONE;
                        end else begin
                            state <= COMMON;
                        end
                    end
                end
                COMMON: begin
                    if (!ra[0] && !rb[0]) begin
                        ra <= ra >> 1;
                        rb <= rb >> 1;
                        k  <= k + KW'(1);
                    end else begin
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (step_done) begin
                        // Restore the common power of two.
                        result <= ra << k;
                        state  <= DONE;
                    end else begin
                        ra <= ra_next;
                        rb <= rb_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == COMMON) || (state == REDUCE);
    assign gcd       = out_valid ? result : '0;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed and randomized checks for gcd_engine
// at WIDTH=8 (directed) and WIDTH=16 (random vs Euclid).
module tb_gcd_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;

    logic        ir8, ov8, busy8;
    logic [7:0]  g8;
    logic        ir16, ov16, busy16;
    logic [15:0] g16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (ir8),
        .a        (a[7:0]),
        .b        (b[7:0]),
        .out_valid(ov8),
        .out_ready(out_ready),
        .gcd      (g8),
        .busy     (busy8)
    );

    gcd_engine #(.WIDTH(16)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (ir16),
        .a        (a),
        .b        (b),
        .out_valid(ov16),
        .out_ready(out_ready),
        .gcd      (g16),
        .busy     (busy16)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    function automatic logic [15:0] euclid(input logic [15:0] x,
                                           input logic [15:0] y);
        logic [15:0] p = x;
        logic [15:0] q = y;
        logic [15:0] t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Issue one pair and wait (bounded) for out_valid.
    task automatic do_op(input bit w16,
                         input logic [15:0] x,
                         input logic [15:0] y,
                         output int lat,
                         output logic [15:0] res,
                         output logic busy1);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        busy1 = w16 ? busy16 : busy8;
        while (!(w16 ? ov16 : ov8) && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        res = w16 ? g16 : {8'h00, g8};
    endtask

    logic [15:0] vx [10];
    logic [15:0] vy [10];
    logic [15:0] vg [10];
    int          vl [10];

    initial begin
        int          lat;
        logic [15:0] res;
        logic        bsy;
        logic        seen;
        logic [15:0] x, y;

        vx = '{48, 0,  0, 37, 255, 128, 221, 7,  12, 1};
        vy = '{18, 37, 0, 0,  255, 64,  13,  13, 18, 1};
        vg = '{6,  37, 0, 37, 255, 64,  13,  1,  6,  1};
        vl = '{8,  1,  1, 1,  3,   10,  7,   7,  6,  3};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(ir8), 1);
        check("rst_out_valid", 32'(ov8), 0);
        check("rst_gcd", 32'(g8), 0);
        check("rst_busy", 32'(busy8), 0);
        check("rst16_gcd", 32'(g16), 0);

        for (int i = 0; i < 10; i++) begin
            do_op(1'b0, vx[i], vy[i], lat, res, bsy);
            check($sformatf("dir%0d_valid", i), 32'(ov8), 1);
            check($sformatf("dir%0d_gcd", i), 32'(res), 32'(vg[i]));
            check($sformatf("dir%0d_lat", i), 32'(lat), 32'(vl[i]));
            check($sformatf("dir%0d_busy", i), 32'(bsy),
                  32'(vx[i] != 0 && vy[i] != 0));
            @(negedge clk);
            check($sformatf("dir%0d_pulse", i), 32'(ov8), 0);
            check($sformatf("dir%0d_idle", i), 32'(ir8), 1);
            check($sformatf("dir%0d_gcd0", i), 32'(g8), 0);
        end

        out_ready = 1'b0;
        do_op(1'b0, 16'd12, 16'd8, lat, res, bsy);
        check("stall_gcd", 32'(res), 4);
        check("stall_lat", 32'(lat), 7);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall%0d_valid", i), 32'(ov8), 1);
            check($sformatf("stall%0d_gcd", i), 32'(g8), 4);
            check($sformatf("stall%0d_ready", i), 32'(ir8), 0);
            in_valid = (i == 2);
            a = 16'd9;
            b = 16'd3;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release", 32'(ov8), 0);
        check("stall_idle", 32'(ir8), 1);

        a = 16'd221;
        b = 16'd13;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy", 32'(busy8), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_idle", 32'(ir8), 1);
        check("midrst_busy0", 32'(busy8), 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = seen | ov8;
            @(negedge clk);
        end
        check("midrst_no_valid", 32'(seen), 0);
        do_op(1'b0, 16'd221, 16'd13, lat, res, bsy);
        check("after_rst_gcd", 32'(res), 13);
        check("after_rst_lat", 32'(lat), 7);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom_range(0, 65535));
            y = 16'($urandom_range(0, 65535));
            if (i % 97 == 5) y = 16'd0;
            if (i % 89 == 7) y = x;
            if (i % 83 == 3) x = 16'h8000;
            check($sformatf("rnd%0d_ready", i), 32'(ir16), 1);
            do_op(1'b1, x, y, lat, res, bsy);
            check($sformatf("rnd%0d_gcd(%0d,%0d)", i, x, y),
                  32'(res), 32'(euclid(x, y)));
            check($sformatf("rnd%0d_lat_ok", i),
                  32'(lat <= 3 * 16 + 3 && ov16), 1);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
